// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the bus, requests to send, clocks out one byte with odd parity and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int RTS_CYCLES     = 20,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       kc,
  input  logic       kd,
  output logic       kc_drive_low,
  output logic       kd_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] error_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_INHIBIT      = 3'd1;
  localparam logic [2:0] S_RTS          = 3'd2;
  localparam logic [2:0] S_SEND         = 3'd3;
  localparam logic [2:0] S_ACK          = 3'd4;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd5;

  logic          kc_meta_q, kc_meta_d, kc_sync_q, kc_sync_d;
  logic          kd_meta_q, kd_meta_d, kd_sync_q, kd_sync_d;
  logic          kc_filt_q, kc_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [2:0]    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          kc_drv_q, kc_drv_d;
  logic          kd_drv_q, kd_drv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          kc_fall;
  logic          timeout_hit;

  always_comb begin
    kc_meta_d = kc;
    kc_sync_d = kc_meta_q;
    kd_meta_d = kd;
    kd_sync_d = kd_meta_q;

    // A new kc level is accepted only after FILTER_LEN consecutive differing samples.
    kc_filt_d  = kc_filt_q;
    filt_cnt_d = '0;
    if (kc_sync_q != kc_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        kc_filt_d = kc_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    kc_fall     = kc_filt_q & ~kc_filt_d;
    timeout_hit = (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    parity_d   = parity_q;
    kc_drv_d   = kc_drv_q;
    kd_drv_d   = kd_drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        kc_drv_d = 1'b0;
        kd_drv_d = 1'b0;
        if (tx_start) begin
          data_d     = tx_data;
          parity_d   = ~^tx_data;
          err_code_d = 2'b00;
          busy_d     = 1'b1;
          kc_drv_d   = 1'b1;
          cnt_d      = '0;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_d    = '0;
          kd_drv_d = 1'b1;
          state_d  = S_RTS;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RTS: begin
        if (cnt_q == 32'(RTS_CYCLES - 1)) begin
          cnt_d     = '0;
          kc_drv_d  = 1'b0;
          kd_drv_d  = 1'b1;
          bit_idx_d = '0;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SEND, S_ACK, S_RELEASE_WAIT: begin
        cnt_d = kc_fall ? 32'd0 : cnt_q + 32'd1;
        if (state_q == S_RELEASE_WAIT && kd_sync_q && kc_filt_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (kc_fall) begin
          if (state_q == S_SEND) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              kd_drv_d = ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              kd_drv_d = ~parity_q;
            end else begin
              kd_drv_d = 1'b0;
              state_d  = S_ACK;
            end
          end else if (state_q == S_ACK) begin
            if (!kd_sync_q) begin
              state_d = S_RELEASE_WAIT;
            end else begin
              error_d    = 1'b1;
              err_code_d = 2'b10;
              busy_d     = 1'b0;
              kc_drv_d   = 1'b0;
              kd_drv_d   = 1'b0;
              state_d    = S_IDLE;
            end
          end
        end else if (timeout_hit) begin
          error_d    = 1'b1;
          err_code_d = 2'b01;
          busy_d     = 1'b0;
          kc_drv_d   = 1'b0;
          kd_drv_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        kc_drv_d = 1'b0;
        kd_drv_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kc_meta_q  <= 1'b1;
      kc_sync_q  <= 1'b1;
      kd_meta_q  <= 1'b1;
      kd_sync_q  <= 1'b1;
      kc_filt_q  <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      kc_drv_q   <= 1'b0;
      kd_drv_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      kc_meta_q  <= kc_meta_d;
      kc_sync_q  <= kc_sync_d;
      kd_meta_q  <= kd_meta_d;
      kd_sync_q  <= kd_sync_d;
      kc_filt_q  <= kc_filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      kc_drv_q   <= kc_drv_d;
      kd_drv_q   <= kd_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign kc_drive_low = kc_drv_q;
  assign kd_drive_low = kd_drv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RTSC = 20;
  localparam int TMO  = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       kc_drive_low, kd_drive_low, busy, done, error;
  logic [1:0] error_code;
  logic       dev_kc_low = 1'b0;
  logic       dev_kd_low = 1'b0;
  logic       dev_abort = 1'b0;
  logic       kc_line, kd_line;
  logic [9:0] dev_frame = '0;
  int         dev_pulses = 0;

  int n_vec = 0;
  int n_err = 0;
  int resp_cnt = 0;
  int cyc = 0;
  int send_cyc = 0;
  int inh_cnt = 0;
  int rts_cnt = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    bit         chk_frame;
    logic [9:0] frame;
    bit         chk_time;
  } exp_t;
  exp_t exp_q[$];

  assign kc_line = ~(kc_drive_low | dev_kc_low);
  assign kd_line = ~(kd_drive_low | dev_kd_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTSC),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .kc          (kc_line),
    .kd          (kd_line),
    .kc_drive_low(kc_drive_low),
    .kd_drive_low(kd_drive_low),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .error_code  (error_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: bus phase lengths and the done/error scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      inh_cnt = 0;
      rts_cnt = 0;
    end else if (kc_drive_low && !kd_drive_low) begin
      inh_cnt++;
    end else if (kc_drive_low && kd_drive_low) begin
      if (inh_cnt != 0) begin
        chk("inhibit_len", inh_cnt, INH);
        inh_cnt = 0;
      end
      rts_cnt++;
    end else begin
      if (!kc_drive_low && kd_drive_low && rts_cnt != 0) begin
        chk("rts_len", rts_cnt, RTSC);
        send_cyc = cyc;
      end
      rts_cnt = 0;
      inh_cnt = 0;
    end
    if (done && error) chk("done_error_overlap", 32'(done & error), 32'd0);
    if (done || error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(error), 32'(e.is_err));
        chk("error_code", 32'(error_code), e.is_err ? 32'(e.code) : 32'd0);
        chk("busy_at_pulse", 32'(busy), 32'd0);
        chk("drives_at_pulse", {30'd0, kc_drive_low, kd_drive_low}, 32'd0);
        if (e.chk_frame) chk("wire_frame", 32'(dev_frame), 32'(e.frame));
        if (e.chk_time) chk("timeout_latency", cyc - send_cyc, TMO);
      end
      resp_cnt++;
    end
  end

  task automatic dev_wait(input int n);
    for (int k = 0; k < n && !dev_abort; k++) @(negedge clk);
  endtask

  // Device: waits for request-to-send, clocks 11 pulses, samples bits on release, ACKs if asked.
  task automatic dev_xfer(input bit ack);
    int n;
    n = 0;
    dev_frame  = '0;
    dev_pulses = 0;
    while (!(kd_line == 1'b0 && kc_line == 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("dev_rts_seen", 32'd0, 32'd1);
      return;
    end
    dev_wait(10);
    for (int i = 0; i < 11; i++) begin
      dev_kc_low = 1'b1;
      dev_pulses = i + 1;
      dev_wait(20);
      dev_kc_low = 1'b0;
      if (i < 10) dev_frame[i] = kd_line;
      if (i == 9) dev_kd_low = ack;
      if (i == 10) dev_kd_low = 1'b0;
      dev_wait(20);
      if (dev_abort) begin
        dev_kd_low = 1'b0;
        return;
      end
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("code_cleared", 32'(error_code), 32'd0);
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrived", 32'(resp_cnt >= target), 32'd1);
    if (resp_cnt < target) exp_q.delete();
  endtask

  task automatic wait_pulses(input int p);
    int n;
    n = 0;
    while (dev_pulses < p && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("dev_pulse_reached", 32'(dev_pulses >= p), 32'd1);
  endtask

  task automatic send_ack(input logic [7:0] d, input logic [9:0] frame);
    int target;
    exp_q.push_back('{1'b0, 2'b00, 1'b1, frame, 1'b0});
    target = resp_cnt + 1;
    start_tx(d);
    dev_xfer(1'b1);
    wait_resp(target);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int target;
    repeat (5) @(negedge clk);
    chk("rst_kc_drive", 32'(kc_drive_low), 32'd0);
    chk("rst_kd_drive", 32'(kd_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_error", {30'd0, done, error}, 32'd0);
    chk("rst_error_code", 32'(error_code), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // frame = {stop, parity, data}
    send_ack(8'hED, 10'h3ED);
    send_ack(8'h01, 10'h201);
    send_ack(8'hFF, 10'h3FF);

    // device never clocks
    exp_q.push_back('{1'b1, 2'b01, 1'b0, 10'h000, 1'b1});
    target = resp_cnt + 1;
    start_tx(8'h3C);
    wait_resp(target);
    repeat (10) @(negedge clk);
    chk("timeout_code_held", 32'(error_code), 32'd1);

    // device NACK
    exp_q.push_back('{1'b1, 2'b10, 1'b1, 10'h3AA, 1'b0});
    target = resp_cnt + 1;
    start_tx(8'hAA);
    dev_xfer(1'b0);
    wait_resp(target);
    repeat (20) @(negedge clk);

    // tx_start while busy is ignored
    exp_q.push_back('{1'b0, 2'b00, 1'b1, 10'h3ED, 1'b0});
    target = resp_cnt + 1;
    start_tx(8'hED);
    fork
      dev_xfer(1'b1);
      begin
        wait_pulses(4);
        repeat (15) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
      end
    join
    wait_resp(target);
    repeat (20) @(negedge clk);

    // reset after kc_fall 5
    start_tx(8'hED);
    fork
      dev_xfer(1'b1);
      begin
        wait_pulses(5);
        repeat (15) @(negedge clk);
        chk("pre_rst_kd_bit4", 32'(kd_drive_low), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_drives", {30'd0, kc_drive_low, kd_drive_low}, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        dev_abort = 1'b1;
      end
    join
    dev_abort = 1'b0;
    repeat (50) @(negedge clk);
    send_ack(8'hF4, 10'h2F4);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
